// File: rtl/finalproject_soc_keycode_fifo.sv
// Avalon-MM keycode FIFO between the NIOS II keyboard driver and the game logic stream port.
// Define KEYCODE_FIFO_IRQ_EN to add the irq output and the register-3 interrupt mask.
module finalproject_soc_keycode_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] last_key
`ifdef KEYCODE_FIFO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  empty;
    logic                  full;
    logic                  wr;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  flush;
    logic                  clear_ovf;
    logic                  unused_writedata;

    assign wr        = chipselect & ~write_n;
    assign push_req  = wr && (address == 2'd0);
    assign flush     = wr && (address == 2'd1) && writedata[0];
    assign clear_ovf = wr && (address == 2'd1) && writedata[2];
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push_req & (~full | pop);

    assign unused_writedata = ^writedata;

    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            last_key <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok && !pop) begin
                    count <= count + 1'b1;
                end else if (!push_ok && pop) begin
                    count <= count - 1'b1;
                end
            end
            if (push_ok) begin
                last_key <= writedata[DATA_WIDTH-1:0];
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef KEYCODE_FIFO_IRQ_EN
    logic [1:0] mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= 2'b00;
            irq  <= 1'b0;
        end else begin
            if (wr && (address == 2'd3)) begin
                mask <= writedata[1:0];
            end
            irq <= (mask[0] & ~empty) | (mask[1] & overflow);
        end
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[DATA_WIDTH-1:0] = out_data;
            2'd1: begin
                readdata[DEPTH_LOG2+8:8] = count;
                readdata[2]              = overflow;
                readdata[1]              = full;
                readdata[0]              = empty;
            end
            2'd2: readdata[DATA_WIDTH-1:0] = last_key;
`ifdef KEYCODE_FIFO_IRQ_EN
            2'd3: readdata[1:0] = mask;
`endif
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_finalproject_soc_keycode_fifo.sv
// Directed bench for the keycode FIFO: a vector table for the basic flows plus hand sequences
// for pointer wrap, flush, asynchronous reset and (with KEYCODE_FIFO_IRQ_EN) the interrupt.
module tb_finalproject_soc_keycode_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  last_key;
`ifdef KEYCODE_FIFO_IRQ_EN
    logic        irq;
`endif

    int vectors_applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t vecs[$];

    finalproject_soc_keycode_fifo dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .last_key(last_key)
`ifdef KEYCODE_FIFO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic void addVec(input logic [1:0] a, input logic cs, input logic wn,
                                   input logic [31:0] wd, input logic rdy, input logic [31:0] er,
                                   input logic ev, input logic [7:0] ed, input logic [7:0] el);
        vec_t v;
        v.addr = a; v.cs = cs; v.wn = wn; v.wdata = wd; v.rdy = rdy;
        v.exp_rd = er; v.exp_valid = ev; v.exp_data = ed; v.exp_last = el;
        vecs.push_back(v);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wn,
                                 input logic [31:0] wd, input logic rdy);
        @(negedge clk);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        out_ready  = rdy;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        logic [7:0] code;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;

        // Table: reset read, basic push/pop, overflow, push-while-full drain.
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h1,   0, 8'h00, 8'h00);
        addVec(2'd0, 0, 0, 32'h77, 0, 32'h0,   0, 8'h00, 8'h00);
        addVec(2'd0, 1, 0, 32'h1A, 0, 32'h0,   0, 8'h00, 8'h00);
        addVec(2'd0, 1, 0, 32'h04, 0, 32'h1A,  1, 8'h1A, 8'h1A);
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h200, 1, 8'h1A, 8'h04);
        addVec(2'd2, 1, 1, 32'h0,  1, 32'h04,  1, 8'h1A, 8'h04);
        addVec(2'd0, 1, 1, 32'h0,  1, 32'h04,  1, 8'h04, 8'h04);
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h1,   0, 8'h00, 8'h04);
        for (int k = 0; k < 9; k++) begin
            if (k == 0) addVec(2'd0, 1, 0, 32'h1, 0, 32'h0, 0, 8'h00, 8'h04);
            else        addVec(2'd0, 1, 0, 32'(k + 1), 0, 32'h01, 1, 8'h01, 8'(k));
        end
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h806, 1, 8'h01, 8'h08);
        addVec(2'd1, 1, 0, 32'h4,  0, 32'h806, 1, 8'h01, 8'h08);
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h802, 1, 8'h01, 8'h08);
        addVec(2'd0, 1, 0, 32'h55, 1, 32'h01,  1, 8'h01, 8'h08);
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h802, 1, 8'h02, 8'h55);
        for (int h = 2; h <= 8; h++) begin
            addVec(2'd0, 1, 1, 32'h0, 1, 32'(h), 1, 8'(h), 8'h55);
        end
        addVec(2'd0, 1, 1, 32'h0,  1, 32'h55,  1, 8'h55, 8'h55);
        addVec(2'd1, 1, 1, 32'h0,  0, 32'h1,   0, 8'h00, 8'h55);
        addVec(2'd2, 1, 0, 32'hAB, 0, 32'h55,  0, 8'h00, 8'h55);
        addVec(2'd2, 1, 1, 32'h0,  0, 32'h55,  0, 8'h00, 8'h55);

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset out_data", 32'(out_data), 32'h0);
        checkOutput("reset last_key", 32'(last_key), 32'h0);
`ifdef KEYCODE_FIFO_IRQ_EN
        checkOutput("reset irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wdata, vecs[i].rdy);
            checkOutput($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d last_key", i), 32'(last_key), 32'(vecs[i].exp_last));
        end

        // Three full fill/drain passes starting from non-zero pointers exercise wrap-around.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                code = 8'h20 + 8'(p * 16) + 8'(i);
                applyStimulus(2'd0, 1, 0, 32'(code), 0);
            end
            applyStimulus(2'd1, 1, 1, 32'h0, 0);
            checkOutput($sformatf("wrap%0d full status", p), readdata, 32'h802);
            for (int i = 0; i < 8; i++) begin
                code = 8'h20 + 8'(p * 16) + 8'(i);
                applyStimulus(2'd0, 1, 1, 32'h0, 1);
                checkOutput($sformatf("wrap%0d head%0d", p, i), readdata, 32'(code));
            end
            applyStimulus(2'd1, 1, 1, 32'h0, 0);
            checkOutput($sformatf("wrap%0d empty status", p), readdata, 32'h1);
        end

        // Flush with a same-cycle pop request: everything goes, last_key stays.
        applyStimulus(2'd0, 1, 0, 32'h31, 0);
        applyStimulus(2'd0, 1, 0, 32'h32, 0);
        applyStimulus(2'd0, 1, 0, 32'h33, 0);
        applyStimulus(2'd1, 1, 0, 32'h1, 1);
        checkOutput("pre-flush head", 32'(out_data), 32'h31);
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("post-flush status", readdata, 32'h1);
        checkOutput("post-flush out_valid", 32'(out_valid), 32'h0);
        checkOutput("post-flush last_key", 32'(last_key), 32'h33);

        // Asynchronous reset with four keycodes queued.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd0, 1, 0, 32'h41 + 32'(i), 0);
        end
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("queued four status", readdata, 32'h400);
        checkOutput("queued four head", 32'(out_data), 32'h41);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("async reset out_data", 32'(out_data), 32'h0);
        checkOutput("async reset last_key", 32'(last_key), 32'h0);
        checkOutput("async reset status", readdata, 32'h1);
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        reset_n = 1'b1;
        applyStimulus(2'd0, 1, 0, 32'h50, 0);
        applyStimulus(2'd0, 1, 1, 32'h0, 0);
        checkOutput("after reset push", readdata, 32'h50);

`ifdef KEYCODE_FIFO_IRQ_EN
        applyStimulus(2'd1, 1, 0, 32'h1, 0);
        applyStimulus(2'd3, 1, 0, 32'h1, 0);
        applyStimulus(2'd0, 1, 0, 32'h2C, 0);
        checkOutput("irq before not-empty", 32'(irq), 32'h0);
        applyStimulus(2'd3, 1, 1, 32'h0, 0);
        checkOutput("irq mask readback", readdata, 32'h1);
        checkOutput("irq not-empty delay", 32'(irq), 32'h0);
        applyStimulus(2'd0, 1, 1, 32'h0, 1);
        checkOutput("irq not-empty asserted", 32'(irq), 32'h1);
        applyStimulus(2'd0, 1, 1, 32'h0, 0);
        checkOutput("irq one cycle after pop", 32'(irq), 32'h1);
        applyStimulus(2'd0, 1, 1, 32'h0, 0);
        checkOutput("irq cleared after pop", 32'(irq), 32'h0);

        applyStimulus(2'd3, 1, 0, 32'h2, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(2'd0, 1, 0, 32'h60 + 32'(i), 0);
        end
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("irq overflow status", readdata, 32'h806);
        checkOutput("irq overflow delay", 32'(irq), 32'h0);
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("irq overflow asserted", 32'(irq), 32'h1);
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("irq overflow held", 32'(irq), 32'h1);
        applyStimulus(2'd1, 1, 0, 32'h4, 0);
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("irq held at clear edge", 32'(irq), 32'h1);
        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        checkOutput("irq after overflow clear", 32'(irq), 32'h0);
        applyStimulus(2'd1, 1, 0, 32'h1, 0);
`else
        applyStimulus(2'd3, 1, 0, 32'h3, 0);
        applyStimulus(2'd3, 1, 1, 32'h0, 0);
        checkOutput("reg3 reads zero", readdata, 32'h0);
`endif

        applyStimulus(2'd1, 1, 1, 32'h0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
